// File: rtl/textcon.sv
// +--------------------------------------------------------------------------+
// | textcon: character stream to text-RAM writer with cursor, scroll, clear  |
// | Optional TEXTCON_FF_EN: form feed homes the cursor and clears the screen |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module textcon #(
  parameter int WORD      = 32,
  parameter int BYTE_CNT  = 4,
  parameter int ADDRW     = 11,
  parameter int CIDXW     = 4,
  parameter int TRAM_HRES = 84,
  parameter int TRAM_VRES = 24
) (
  input  logic                clk_sys,
  input  logic                rst_sys,
  input  logic [7:0]          ch_data,
  input  logic [CIDXW-1:0]    ch_fg,
  input  logic [CIDXW-1:0]    ch_bg,
  input  logic                ch_valid,
  output logic                ch_ready,
  output logic [BYTE_CNT-1:0] tram_we,
  output logic [ADDRW-1:0]    tram_addr,
  output logic [WORD-1:0]     tram_din,
  output logic [ADDRW-1:0]    scroll_offs,
  output logic [ADDRW-1:0]    cur_col,
  output logic [ADDRW-1:0]    cur_row
);

  localparam logic [ADDRW:0]   c_total_w = (ADDRW+1)'(TRAM_HRES * TRAM_VRES);
  localparam logic [ADDRW:0]   c_hres_w  = (ADDRW+1)'(TRAM_HRES);
  localparam logic [ADDRW-1:0] c_row_max = ADDRW'(TRAM_VRES - 1);
  localparam logic [7:0]       c_lf      = 8'h0A;
  localparam logic [7:0]       c_cr      = 8'h0D;
  localparam logic [7:0]       c_bs      = 8'h08;
  localparam logic [7:0]       c_sp      = 8'h20;
`ifdef TEXTCON_FF_EN
  localparam logic [7:0]       c_ff      = 8'h0C;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_SCROLL, S_CLEAR} state_t;

  state_t                r_state;
  logic [7:0]            r_code;
  logic [CIDXW-1:0]      r_fg;
  logic [CIDXW-1:0]      r_bg;
  logic [ADDRW-1:0]      r_scroll;
  logic [ADDRW-1:0]      r_col;
  logic [ADDRW-1:0]      r_row;
  logic [BYTE_CNT-1:0]   r_we;
  logic [ADDRW-1:0]      r_addr;
  logic [WORD-1:0]       r_din;
  logic [ADDRW-1:0]      r_clr_next;
  logic [ADDRW:0]        r_clr_left;

  logic [ADDRW:0]        w_lin;
  logic [ADDRW-1:0]      w_wr_addr;
  logic [ADDRW:0]        w_col_inc;
  logic                  w_print;
  logic                  w_newline;

  // Both operands are below the screen size, so one conditional subtract wraps.
  function automatic logic [ADDRW-1:0] wrap_add(input logic [ADDRW:0] a, input logic [ADDRW:0] b);
    logic [ADDRW:0] s;
    s = a + b;
    if (s >= c_total_w) s = s - c_total_w;
    return s[ADDRW-1:0];
  endfunction

  function automatic logic [WORD-1:0] pack_word(input logic [7:0] code, input logic [CIDXW-1:0] fg,
                                                input logic [CIDXW-1:0] bg);
    logic [WORD-1:0] w;
    w = '0;
    w[7:0] = code;
    w[8 +: CIDXW] = fg;
    w[8+CIDXW +: CIDXW] = bg;
    return w;
  endfunction

  function automatic logic is_print(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

  assign w_lin     = {1'b0, r_row} * c_hres_w + {1'b0, r_col};
  assign w_wr_addr = wrap_add(w_lin, {1'b0, r_scroll});
  assign w_col_inc = {1'b0, r_col} + (ADDRW+1)'(1);
  assign w_print   = is_print(r_code);
  assign w_newline = (w_print && (w_col_inc == c_hres_w)) || (r_code == c_lf);

  assign ch_ready    = (r_state == S_IDLE) && !rst_sys;
  assign tram_we     = r_we;
  assign tram_addr   = r_addr;
  assign tram_din    = r_din;
  assign scroll_offs = r_scroll;
  assign cur_col     = r_col;
  assign cur_row     = r_row;

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      r_state    <= S_IDLE;
      r_code     <= '0;
      r_fg       <= '0;
      r_bg       <= '0;
      r_scroll   <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_we       <= '0;
      r_addr     <= '0;
      r_din      <= '0;
      r_clr_next <= '0;
      r_clr_left <= '0;
    end else begin
      r_we <= '0;
      case (r_state)
        S_IDLE: begin
          if (ch_valid && ch_ready) begin
            r_code  <= ch_data;
            r_fg    <= ch_fg;
            r_bg    <= ch_bg;
            r_state <= S_WRITE;
            // Write strobe is launched here so it is high during the WRITE cycle.
            if (is_print(ch_data)) begin
              r_we   <= '1;
              r_addr <= w_wr_addr;
              r_din  <= pack_word(ch_data, ch_fg, ch_bg);
            end
          end
        end
        S_WRITE: begin
          r_state <= S_IDLE;
          if (w_newline) begin
            r_col <= '0;
            if (r_row == c_row_max) r_state <= S_SCROLL;
            else r_row <= r_row + ADDRW'(1);
          end else if (w_print) begin
            r_col <= w_col_inc[ADDRW-1:0];
          end else if (r_code == c_cr) begin
            r_col <= '0;
          end else if (r_code == c_bs) begin
            if (r_col != '0) r_col <= r_col - ADDRW'(1);
          end
`ifdef TEXTCON_FF_EN
          else if (r_code == c_ff) begin
            r_scroll   <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_we       <= '1;
            r_addr     <= '0;
            r_din      <= pack_word(c_sp, r_fg, r_bg);
            r_clr_next <= wrap_add('0, (ADDRW+1)'(1));
            r_clr_left <= c_total_w - (ADDRW+1)'(1);
            r_state    <= S_CLEAR;
          end
`endif
        end
        S_SCROLL: begin
          r_we       <= '1;
          r_addr     <= r_scroll;
          r_din      <= pack_word(c_sp, r_fg, r_bg);
          r_clr_next <= wrap_add({1'b0, r_scroll}, (ADDRW+1)'(1));
          r_clr_left <= c_hres_w - (ADDRW+1)'(1);
          r_scroll   <= wrap_add({1'b0, r_scroll}, c_hres_w);
          r_state    <= S_CLEAR;
        end
        S_CLEAR: begin
          if (r_clr_left == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_we       <= '1;
            r_addr     <= r_clr_next;
            r_din      <= pack_word(c_sp, r_fg, r_bg);
            r_clr_next <= wrap_add({1'b0, r_clr_next}, (ADDRW+1)'(1));
            r_clr_left <= r_clr_left - (ADDRW+1)'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_textcon.sv
// +--------------------------------------------------------------------------+
// | tb_textcon: randomized self-checking bench for textcon against a         |
// | character-level screen model. Revision: 1.0                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_textcon;

  localparam int HRES  = 84;
  localparam int VRES  = 24;
  localparam int TOTAL = HRES * VRES;

  logic        clk_sys = 1'b0;
  logic        rst_sys = 1'b1;
  logic [7:0]  ch_data = 8'h00;
  logic [3:0]  ch_fg = 4'h0;
  logic [3:0]  ch_bg = 4'h0;
  logic        ch_valid = 1'b0;
  logic        ch_ready;
  logic [3:0]  tram_we;
  logic [10:0] tram_addr;
  logic [31:0] tram_din;
  logic [10:0] scroll_offs;
  logic [10:0] cur_col;
  logic [10:0] cur_row;

  textcon dut (
    .clk_sys    (clk_sys),
    .rst_sys    (rst_sys),
    .ch_data    (ch_data),
    .ch_fg      (ch_fg),
    .ch_bg      (ch_bg),
    .ch_valid   (ch_valid),
    .ch_ready   (ch_ready),
    .tram_we    (tram_we),
    .tram_addr  (tram_addr),
    .tram_din   (tram_din),
    .scroll_offs(scroll_offs),
    .cur_col    (cur_col),
    .cur_row    (cur_row)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk_sys) cyc++;

  int obs_a[$];
  int obs_d[$];
  int exp_a[$];
  int exp_d[$];

  int m_col = 0;
  int m_row = 0;
  int m_scroll = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_sys) begin
    if (tram_we != 4'h0) begin
      obs_a.push_back(int'(tram_addr));
      obs_d.push_back(int'(tram_din));
      check("we_all_ones", tram_we, 4'hF);
    end
  end

  function automatic int word(input int code, input int fg, input int bg);
    return code + fg * 256 + bg * 4096;
  endfunction

  // Screen model: what each character does to cursor, scroll and tram.
  task automatic model_char(input int c, input int f, input int b, output int busy);
    bit nl;
    nl = 0;
    busy = 1;
    if (c >= 32 && c <= 126) begin
      exp_a.push_back((m_scroll + m_row * HRES + m_col) % TOTAL);
      exp_d.push_back(word(c, f, b));
      m_col++;
      if (m_col == HRES) nl = 1;
    end else if (c == 10) nl = 1;
    else if (c == 13) m_col = 0;
    else if (c == 8) begin
      if (m_col > 0) m_col--;
    end
`ifdef TEXTCON_FF_EN
    else if (c == 12) begin
      m_scroll = 0; m_col = 0; m_row = 0;
      for (int i = 0; i < TOTAL; i++) begin
        exp_a.push_back(i);
        exp_d.push_back(word(32, f, b));
      end
      busy += TOTAL;
    end
`endif
    if (nl) begin
      m_col = 0;
      if (m_row == VRES - 1) begin
        for (int i = 0; i < HRES; i++) begin
          exp_a.push_back((m_scroll + i) % TOTAL);
          exp_d.push_back(word(32, f, b));
        end
        m_scroll = (m_scroll + HRES) % TOTAL;
        busy += 1 + HRES;
      end else m_row++;
    end
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check({tag, "_wr_count"}, obs_a.size(), exp_a.size());
    n = (obs_a.size() < exp_a.size()) ? obs_a.size() : exp_a.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_wr_addr"}, obs_a[i], exp_a[i]);
      check({tag, "_wr_data"}, obs_d[i], exp_d[i]);
    end
    obs_a.delete(); obs_d.delete(); exp_a.delete(); exp_d.delete();
  endtask

  task automatic check_cursor(input string tag);
    check({tag, "_col"}, cur_col, m_col);
    check({tag, "_row"}, cur_row, m_row);
    check({tag, "_scroll"}, scroll_offs, m_scroll);
  endtask

  task automatic wait_ready();
    int g;
    g = 0;
    @(negedge clk_sys);
    while (!ch_ready && g < 5000) begin g++; @(negedge clk_sys); end
    if (!ch_ready) check("ready_wait", ch_ready, 1'b1);
  endtask

  task automatic send_char(input string tag, input int c, input int f, input int b);
    int busy, eb, g;
    wait_ready();
    ch_data = 8'(c); ch_fg = 4'(f); ch_bg = 4'(b); ch_valid = 1'b1;
    @(posedge clk_sys); #1;
    ch_valid = 1'b0;
    model_char(c, f, b, eb);
    busy = 0; g = 0;
    @(negedge clk_sys);
    while (!ch_ready && g < 5000) begin busy++; g++; @(negedge clk_sys); end
    check({tag, "_busy"}, busy, eb);
    compare_writes(tag);
    check_cursor(tag);
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    rst_sys = 1'b1; ch_valid = 1'b0;
    @(negedge clk_sys);
    check("rst_ready", ch_ready, 1'b0);
    check("rst_we", tram_we, 4'h0);
    @(negedge clk_sys);
    rst_sys = 1'b0;
    m_col = 0; m_row = 0; m_scroll = 0;
    @(negedge clk_sys);
    obs_a.delete(); obs_d.delete(); exp_a.delete(); exp_d.delete();
    check_cursor("after_rst");
    check("after_rst_ready", ch_ready, 1'b1);
  endtask

  function automatic int rand_code();
    int r, c;
    r = $urandom_range(0, 99);
    if (r < 60) c = $urandom_range(32, 126);
    else if (r < 75) c = 10;
    else if (r < 83) c = 13;
    else if (r < 91) c = 8;
    else if (r < 97) begin
      c = $urandom_range(0, 31);
      if (c == 8 || c == 10 || c == 12 || c == 13) c = 127;
    end else c = 12;
    return c;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, f, b, eb, g, t0, t1;
    t0 = 0; t1 = 0;
    repeat (3) @(posedge clk_sys);
    do_reset();

    send_char("char_A", 8'h41, 7, 0);
    send_char("cr", 13, 1, 2);

    // Back-to-back characters with ch_valid held high across a full line.
    wait_ready();
    ch_valid = 1'b1;
    for (int i = 0; i < HRES; i++) begin
      c = $urandom_range(32, 126); f = $urandom_range(0, 15); b = $urandom_range(0, 15);
      ch_data = 8'(c); ch_fg = 4'(f); ch_bg = 4'(b);
      g = 0;
      while (!ch_ready && g < 100) begin g++; @(negedge clk_sys); end
      @(posedge clk_sys); #1;
      if (i == 0) t0 = cyc;
      t1 = cyc;
      model_char(c, f, b, eb);
      @(negedge clk_sys);
    end
    ch_valid = 1'b0;
    wait_ready();
    check("burst_spacing", t1 - t0, 2 * (HRES - 1));
    compare_writes("burst");
    check_cursor("burst");

    for (int i = 0; i < 200; i++)
      send_char("rand", rand_code(), $urandom_range(0, 15), $urandom_range(0, 15));

    // From home, 23 LFs reach the last row; the next 24 each scroll, ending in a wrap.
    do_reset();
    for (int i = 0; i < 47; i++)
      send_char("lf", 10, $urandom_range(0, 15), $urandom_range(0, 15));
    check("scroll_wrapped", scroll_offs, 0);

    // Reset during a clear: 11 words get written before reset takes effect.
    wait_ready();
    ch_data = 8'h0A; ch_fg = 4'h5; ch_bg = 4'h9; ch_valid = 1'b1;
    @(posedge clk_sys); #1;
    ch_valid = 1'b0;
    model_char(10, 5, 9, eb);
    repeat (12) @(posedge clk_sys);
    #1 rst_sys = 1'b1;
    @(posedge clk_sys); #1;
    check("midclr_we", tram_we, 4'h0);
    check("midclr_ready", ch_ready, 1'b0);
    check("midclr_col", cur_col, 0);
    check("midclr_row", cur_row, 0);
    check("midclr_scroll", scroll_offs, 0);
    @(negedge clk_sys);
    rst_sys = 1'b0;
    repeat (5) @(negedge clk_sys);
    while (exp_a.size() > 11) begin void'(exp_a.pop_back()); void'(exp_d.pop_back()); end
    compare_writes("midclr");
    m_col = 0; m_row = 0; m_scroll = 0;

    send_char("ff", 12, 3, 5);
    send_char("char_B", 8'h42, 2, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/textcon.md
TEXTCON -- requirements
Module: textcon

Interface
REQ-001 SHALL have parameter WORD, default 32, tram word width (bits).
REQ-002 SHALL have parameter BYTE_CNT, default 4, tram byte-write-enable width.
REQ-003 SHALL have parameter ADDRW, default 11, tram address width.
REQ-004 SHALL have parameter CIDXW, default 4, colour index width.
REQ-005 SHALL have parameters TRAM_HRES, default 84, and TRAM_VRES, default 24, text grid size in chars; HRES*VRES SHALL be at most 2^ADDRW.
REQ-006 SHALL have port clk_sys, input, 1, system clock; the block uses one clock only.
REQ-007 SHALL have port rst_sys, input, 1, reset, synchronous and active-high.
REQ-008 SHALL have port ch_data, input, 8, character code.
REQ-009 SHALL have port ch_fg, input, CIDXW, foreground colour index.
REQ-010 SHALL have port ch_bg, input, CIDXW, background colour index.
REQ-011 SHALL have port ch_valid, input, 1, character offered.
REQ-012 SHALL have port ch_ready, output, 1, block can accept a character.
REQ-013 SHALL have port tram_we, output, BYTE_CNT, tram byte write enables.
REQ-014 SHALL have port tram_addr, output, ADDRW, tram word address.
REQ-015 SHALL have port tram_din, output, WORD, tram write data.
REQ-016 SHALL have port scroll_offs, output, ADDRW, first displayed word; feeds the textmode scroll input.
REQ-017 SHALL have ports cur_col, output, ADDRW, and cur_row, output, ADDRW, cursor position.

Function
REQ-018 Tram word SHALL be [7:0] code, [7+CIDXW:8] fg, [7+2*CIDXW:8+CIDXW] bg, all remaining bits zero.
REQ-019 States SHALL be IDLE, WRITE, SCROLL, CLEAR; ch_ready SHALL be high only in IDLE and not in reset.
REQ-020 A character SHALL be accepted when ch_valid and ch_ready are both high at a clock edge; ch_data, ch_fg and ch_bg SHALL be captured then, and the FSM SHALL enter WRITE.
REQ-021 In WRITE, a printable code (0x20-0x7E) SHALL set tram_we to all ones for exactly that one cycle, with tram_addr = (scroll_offs + cur_row*HRES + cur_col) mod (HRES*VRES), and advance cur_col.
REQ-022 When cur_col reaches HRES, or on LF (0x0A), cur_col SHALL become 0 and cur_row SHALL increment; if cur_row was VRES-1, cur_row SHALL hold and the FSM SHALL go to SCROLL, otherwise to IDLE.
REQ-023 CR (0x0D) SHALL set cur_col to 0; BS (0x08) SHALL decrement cur_col if it is nonzero; all other codes SHALL be consumed with no tram write.
REQ-024 SCROLL (1 cycle) SHALL latch the clear base equal to the old scroll_offs, set scroll_offs = (old + HRES) mod (HRES*VRES), then enter CLEAR.
REQ-025 CLEAR SHALL write HRES consecutive words, one per cycle, starting at the clear base and wrapping mod HRES*VRES; each word SHALL be code 0x20 with the captured fg/bg; the FSM SHALL then return to IDLE.
REQ-026 tram_we SHALL be 0 in every cycle not specified above; tram_addr and tram_din are don't-care when tram_we is 0.
REQ-027 All address arithmetic SHALL be performed at ADDRW+1 bits or wider before the modulo, and SHALL never emit an address at or above HRES*VRES.

Reset
REQ-028 On rst_sys the block SHALL set state IDLE, scroll_offs 0, cur_col 0, cur_row 0, tram_we 0, and hold ch_ready 0 during reset.
REQ-029 Reset asserted mid-CLEAR SHALL abort the clear immediately; no further writes SHALL occur and partly cleared tram content SHALL remain.

Configuration
REQ-030 With macro TEXTCON_FF_EN defined, FF (0x0C) SHALL set scroll_offs, cur_col and cur_row to 0, then run CLEAR over all HRES*VRES words starting at address 0; without the macro, FF SHALL be consumed with no effect.

Verification
REQ-031 Reset; send 'A' (0x41), fg 7, bg 0 -> one write to addr 0, data 0x00000741; cur_col becomes 1.
REQ-032 Hold ch_valid high with 84 printable chars -> addrs 0..83, one accept per 2 cycles, then cur_row 1 and cur_col 0.
REQ-033 At cur_row 23, send LF -> scroll_offs becomes 84; 84 writes of 0x20 at addrs 0..83; ch_ready low for 86 cycles.
REQ-034 After 23 scrolls (scroll_offs 1932), send LF -> clear writes at 1932..2015, scroll_offs wraps to 0.
REQ-035 Assert rst_sys after 10 CLEAR cycles -> tram_we 0 on the next cycle, all outputs at reset values.
REQ-036 With TEXTCON_FF_EN, send 0x0C -> 2016 writes at addrs 0..2015, cursor 0,0; without it, no writes occur.
